decode_issue_queue: RTL and testbench
=====================================

DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries; power of 2, at least 2.
REQ-002 SHALL have parameter NUM_FU, default 4: functional-unit channels (0 ARITH, 1 MUL, 2 DIV, 3 LSU).
REQ-003 SHALL have parameter REG_W, default 5: register-index width.
REQ-004 SHALL have port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have ports enq_valid in 1 / enq_ready out 1: enqueue handshake from decode.
REQ-007 SHALL have ports enq_instr in 32, enq_fu in clog2(NUM_FU), enq_rd/enq_rs1/enq_rs2 in REG_W, enq_wen in 1: decoded bundle.
REQ-008 SHALL have port iss_valid  out  NUM_FU  one-hot issue request to the head entry's FU.
REQ-009 SHALL have port iss_ready  in  NUM_FU  per-FU accept.
REQ-010 SHALL have ports iss_instr out 32, iss_rd out REG_W, iss_wen out 1: head entry fields.
REQ-011 SHALL have ports wb_valid in 1 / wb_rd in REG_W: writeback retire; clears a pending bit.
REQ-012 SHALL have port flush  in  1  discards all queued entries.
REQ-013 SHALL have port count  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-014 SHALL store entries in a circular buffer with head/tail pointers wrapping modulo DEPTH.
REQ-015 SHALL drive enq_ready = (count < DEPTH); enqueue fires on enq_valid & enq_ready.
REQ-016 SHALL NOT bypass: an entry enqueued in cycle N is visible at head no earlier than cycle N+1.
REQ-017 SHALL keep a scoreboard of 2^REG_W pending-write bits; bit 0 is never set.
REQ-018 SHALL flag a head hazard when scoreboard[rs1] or scoreboard[rs2] is set (index 0 ignored), or when iss_wen and scoreboard[rd] is set.
REQ-019 SHALL evaluate hazards on the registered scoreboard only; no same-cycle writeback forwarding.
REQ-020 SHALL assert iss_valid[enq_fu of head] alone when count > 0, no hazard, flush low; else all zero.
REQ-021 SHALL fire an issue on iss_valid[k] & iss_ready[k]: pop head; if iss_wen and iss_rd != 0, set scoreboard[iss_rd].
REQ-022 SHALL, once iss_valid is asserted, hold it and all iss_* fields stable until fire or flush.
REQ-023 SHALL clear scoreboard[wb_rd] on wb_valid; if the same index is set by an issue that cycle, set wins.
REQ-024 SHALL allow enqueue and issue in one cycle: count unchanged, both pointers advance.
REQ-025 SHALL, on flush, zero count and both pointers next edge, ignore enqueue and issue that cycle, and retain the scoreboard.
REQ-026 SHALL process wb_valid normally during flush.
REQ-027 SHALL keep count in 0..DEPTH; overflow and underflow are impossible by construction.

Reset
REQ-028 SHALL, while RST is high, immediately force count=0, head=tail=0, scoreboard all zero, iss_valid=0, enq_ready=1.
REQ-029 SHALL discard a reset mid-operation, including in-flight entries and pending bits; entry storage contents need no reset.

Verification
REQ-030 SHALL test fill/drain: 4 enqueues with iss_ready=0 -> count=4, enq_ready=0; then iss_ready=all 1s -> entries issue in order, one per cycle, count reaches 0.
REQ-031 SHALL test RAW: issue rd=5 to MUL, then head rs1=5 -> iss_valid=0 until wb_valid/wb_rd=5; iss_valid[ARITH]=1 the cycle after writeback.
REQ-032 SHALL test the collision: issue of rd=7 and wb_rd=7 in the same cycle -> scoreboard[7]=1 afterwards.
REQ-033 SHALL test x0: rd=0/wen=1 issue, then head rs1=0 -> no stall, scoreboard[0] stays 0.
REQ-034 SHALL test flush at count=3 with enq_valid=1 -> count=0 next cycle, iss_valid=0, pending bits kept.
REQ-035 SHALL test reset asserted mid-stream, asynchronously between edges -> outputs at reset values before the next CLK edge.

Source files
------------

// File: rtl/decode_issue_queue.sv
// Decode-to-issue queue: circular buffer of decoded ops with a
// pending-write scoreboard gating in-order issue to functional units.
module decode_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int NUM_FU = 4,
  parameter int REG_W  = 5,
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [31:0]       enq_instr,
  input  logic [FU_W-1:0]   enq_fu,
  input  logic [REG_W-1:0]  enq_rd,
  input  logic [REG_W-1:0]  enq_rs1,
  input  logic [REG_W-1:0]  enq_rs2,
  input  logic              enq_wen,
  output logic [NUM_FU-1:0] iss_valid,
  input  logic [NUM_FU-1:0] iss_ready,
  output logic [31:0]       iss_instr,
  output logic [REG_W-1:0]  iss_rd,
  output logic              iss_wen,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam int NREG = 1 << REG_W;

  logic [31:0]      instr_mem [DEPTH];
  logic [FU_W-1:0]  fu_mem    [DEPTH];
  logic [REG_W-1:0] rd_mem    [DEPTH];
  logic [REG_W-1:0] rs1_mem   [DEPTH];
  logic [REG_W-1:0] rs2_mem   [DEPTH];
  logic             wen_mem   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [NREG-1:0]  sb;
  logic [NREG-1:0]  sb_next;

  logic [FU_W-1:0]  head_fu;
  logic [REG_W-1:0] head_rs1;
  logic [REG_W-1:0] head_rs2;
  logic             hazard;
  logic             enq_fire;
  logic             iss_fire;

  assign enq_ready = (count < CNT_W'(DEPTH));
  assign enq_fire  = enq_valid & enq_ready & ~flush;
  assign iss_fire  = |(iss_valid & iss_ready);

  assign head_fu   = fu_mem[head];
  assign head_rs1  = rs1_mem[head];
  assign head_rs2  = rs2_mem[head];
  assign iss_instr = instr_mem[head];
  assign iss_rd    = rd_mem[head];
  assign iss_wen   = wen_mem[head];

  // Head hazard from registered pending bits; x0 never stalls.
  always_comb begin
    hazard = 1'b0;
    if (head_rs1 != '0 && sb[head_rs1])
      hazard = 1'b1;
    if (head_rs2 != '0 && sb[head_rs2])
      hazard = 1'b1;
    if (iss_wen && iss_rd != '0 && sb[iss_rd])
      hazard = 1'b1;
  end

  // One-hot request to the head entry's functional unit.
  always_comb begin
    iss_valid = '0;
    if (count != '0 && !hazard && !flush)
      iss_valid[head_fu] = 1'b1;
  end

  // Scoreboard update: writeback clears, issue sets, set wins.
  always_comb begin
    sb_next = sb;
    if (wb_valid)
      sb_next[wb_rd] = 1'b0;
    if (iss_fire && iss_wen && iss_rd != '0)
      sb_next[iss_rd] = 1'b1;
  end

  // Pending-write bits survive flush, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      sb <= '0;
    else
      sb <= sb_next;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire)
        tail <= tail + PTR_W'(1);
      if (iss_fire)
        head <= head + PTR_W'(1);
      unique case ({enq_fire, iss_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; contents are don't-care until enqueued.
  always_ff @(posedge CLK) begin
    if (enq_fire) begin
      instr_mem[tail] <= enq_instr;
      fu_mem[tail]    <= enq_fu;
      rd_mem[tail]    <= enq_rd;
      rs1_mem[tail]   <= enq_rs1;
      rs2_mem[tail]   <= enq_rs2;
      wen_mem[tail]   <= enq_wen;
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: expected issue
// order kept in a queue, popped whenever an issue fires.
module tb_decode_issue_queue;

  localparam int ARITH = 0;
  localparam int MUL   = 1;
  localparam int DIV   = 2;
  localparam int LSU   = 3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] instr;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_instr = '0;
  logic [1:0]  enq_fu = '0;
  logic [4:0]  enq_rd = '0;
  logic [4:0]  enq_rs1 = '0;
  logic [4:0]  enq_rs2 = '0;
  logic        enq_wen = 1'b0;
  logic [3:0]  iss_valid;
  logic [3:0]  iss_ready = '0;
  logic [31:0] iss_instr;
  logic [4:0]  iss_rd;
  logic        iss_wen;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic [2:0]  count;

  int n_checks = 0;
  int n_err    = 0;
  exp_t exp_q[$];

  decode_issue_queue dut (
    .CLK(CLK), .RST(RST),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_instr(enq_instr), .enq_fu(enq_fu),
    .enq_rd(enq_rd), .enq_rs1(enq_rs1),
    .enq_rs2(enq_rs2), .enq_wen(enq_wen),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_instr(iss_instr), .iss_rd(iss_rd),
    .iss_wen(iss_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic enq(input logic [31:0] ins, input int fu,
                     input int rd, input int rs1, input int rs2,
                     input logic wen);
    exp_t e;
    enq_instr = ins;
    enq_fu    = 2'(fu);
    enq_rd    = 5'(rd);
    enq_rs1   = 5'(rs1);
    enq_rs2   = 5'(rs2);
    enq_wen   = wen;
    enq_valid = 1'b1;
    e.rd      = 5'(rd);
    e.instr   = ins;
    exp_q.push_back(e);
    tick();
    enq_valid = 1'b0;
  endtask

  // Pop and compare on every handshake that will fire next edge.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && (iss_valid & iss_ready) != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 32'(iss_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("iss_instr", iss_instr, e.instr);
        check("iss_rd", 32'(iss_rd), 32'(e.rd));
      end
    end
  end

  initial begin
    // reset state
    tick();
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_enq_ready", 32'(enq_ready), 32'd1);
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    RST = 1'b0;
    tick();

    // fill then drain
    iss_ready = 4'h0;
    enq(32'hA000_0001, DIV, 1, 0, 0, 1'b0);
    enq(32'hA000_0002, ARITH, 2, 0, 0, 1'b0);
    enq(32'hA000_0003, LSU, 3, 0, 0, 1'b0);
    enq(32'hA000_0004, MUL, 4, 0, 0, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_enq_ready", 32'(enq_ready), 32'd0);
    check("full_iss_valid", 32'(iss_valid), 32'b0100);
    iss_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_count", 32'(count), 32'(3 - i));
    end
    check("drain_q_empty", 32'(exp_q.size()), 32'd0);

    // RAW on rd=5
    enq_instr = 32'hB000_0001;
    enq_fu = 2'(MUL);
    enq_rd = 5'd5;
    enq_rs1 = 5'd0;
    enq_rs2 = 5'd0;
    enq_wen = 1'b1;
    enq_valid = 1'b1;
    #1;
    check("no_bypass", 32'(iss_valid), 32'd0);
    exp_q.push_back('{rd: 5'd5, instr: 32'hB000_0001});
    tick();
    enq_valid = 1'b0;
    check("mul_valid", 32'(iss_valid), 32'b0010);
    enq(32'hB000_0002, ARITH, 6, 5, 0, 1'b0);
    check("enq_iss_count", 32'(count), 32'd1);
    check("raw_stall0", 32'(iss_valid), 32'd0);
    tick();
    tick();
    check("raw_stall2", 32'(iss_valid), 32'd0);
    wb_valid = 1'b1;
    wb_rd = 5'd5;
    #1;
    check("raw_no_fwd", 32'(iss_valid), 32'd0);
    tick();
    wb_valid = 1'b0;
    check("raw_release", 32'(iss_valid), 32'b0001);
    tick();

    // issue-set and writeback-clear of rd=7 in one cycle
    enq(32'hC000_0001, LSU, 7, 0, 0, 1'b1);
    check("lsu_valid", 32'(iss_valid), 32'b1000);
    wb_valid = 1'b1;
    wb_rd = 5'd7;
    tick();
    wb_valid = 1'b0;
    enq(32'hC000_0002, ARITH, 8, 0, 7, 1'b0);
    check("coll_stall0", 32'(iss_valid), 32'd0);
    tick();
    check("coll_stall1", 32'(iss_valid), 32'd0);
    wb_valid = 1'b1;
    wb_rd = 5'd7;
    tick();
    wb_valid = 1'b0;
    check("coll_release", 32'(iss_valid), 32'b0001);
    tick();

    // x0 never pending
    enq(32'hD000_0001, ARITH, 0, 0, 0, 1'b1);
    enq(32'hD000_0002, DIV, 0, 0, 0, 1'b1);
    check("x0_no_stall", 32'(iss_valid), 32'b0100);
    tick();
    check("x0_count", 32'(count), 32'd0);

    // flush at count=3 keeps pending bits
    enq(32'hE000_0001, ARITH, 9, 0, 0, 1'b1);
    tick();
    iss_ready = 4'h0;
    enq(32'hE000_0002, ARITH, 0, 0, 0, 1'b0);
    enq(32'hE000_0003, MUL, 0, 0, 0, 1'b0);
    enq(32'hE000_0004, DIV, 0, 0, 0, 1'b0);
    check("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    enq_valid = 1'b1;
    #1;
    check("flush_iss_valid", 32'(iss_valid), 32'd0);
    tick();
    flush = 1'b0;
    enq_valid = 1'b0;
    exp_q.delete();
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid_after", 32'(iss_valid), 32'd0);
    iss_ready = 4'hF;
    enq(32'hE000_0005, ARITH, 0, 9, 0, 1'b0);
    tick();
    check("flush_kept_sb", 32'(iss_valid), 32'd0);
    wb_valid = 1'b1;
    wb_rd = 5'd9;
    tick();
    wb_valid = 1'b0;
    check("flush_release", 32'(iss_valid), 32'b0001);
    tick();

    // async reset mid-stream
    enq(32'hF000_0001, MUL, 12, 0, 0, 1'b1);
    tick();
    iss_ready = 4'h0;
    enq(32'hF000_0002, LSU, 0, 0, 0, 1'b0);
    enq(32'hF000_0003, ARITH, 0, 0, 0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd2);
    #2;
    RST = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_enq_ready", 32'(enq_ready), 32'd1);
    check("arst_iss_valid", 32'(iss_valid), 32'd0);
    exp_q.delete();
    tick();
    RST = 1'b0;
    iss_ready = 4'hF;
    enq(32'hF000_0004, ARITH, 0, 12, 0, 1'b0);
    check("arst_sb_clear", 32'(iss_valid), 32'b0001);
    tick();
    tick();
    check("final_count", 32'(count), 32'd0);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
